// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: control-bundle layout, NOP constant and field widths shared by the ID/EX pipeline register
package id_ex_reg_pkg;
    localparam int CTRL_W         = 8;
    localparam int ALU_SRC_BIT    = 7;
    localparam int MEM_TO_REG_BIT = 6;
    localparam int REG_WRITE_BIT  = 5;
    localparam int MEM_READ_BIT   = 4;
    localparam int MEM_WRITE_BIT  = 3;
    localparam int BRANCH_BIT     = 2;
    localparam int ALU_OP_HI      = 1;
    localparam int ALU_OP_LO      = 0;
    localparam int REG_IDX_W      = 5;
    localparam int FUNCT_W        = 4;
    localparam logic [CTRL_W-1:0] NOP_CTRL = 8'h00;
endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: W-bit pipeline field (clk, async reset, en = load, clr = load zero instead of d, d -> q)
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (en) q <= clr ? '0 : d;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID->EX pipeline register (hold/bubble/flush controls, id_* in, ex_* out, saturating bubble_cnt)
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 bubble,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [CTRL_W-1:0]    id_ctrl,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [FUNCT_W-1:0]   id_funct,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [FUNCT_W-1:0]   ex_funct,
    output logic                 ex_valid,
    output logic [CNT_W-1:0]     bubble_cnt
);
    localparam int DATA_W = 4*XLEN + 3*REG_IDX_W + FUNCT_W;
    logic load, kill, cnt_en;
    // flush overrides hold, so a flushed slot always loads
    assign load   = flush | ~hold;
    assign kill   = flush | bubble;
    assign cnt_en = load & kill & ~&bubble_cnt;
    // valid and ctrl share one register so an invalid slot can never carry control bits
    pipe_field_reg #(.W(CTRL_W+1)) u_ctrl (
        .clk(clk), .reset(reset), .en(load), .clr(kill | ~id_valid),
        .d({id_valid, id_ctrl}), .q({ex_valid, ex_ctrl})
    );
    pipe_field_reg #(.W(DATA_W)) u_data (
        .clk(clk), .reset(reset), .en(load), .clr(1'b0),
        .d({id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct}),
        .q({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct})
    );
    pipe_field_reg #(.W(CNT_W)) u_cnt (
        .clk(clk), .reset(reset), .en(cnt_en), .clr(1'b0),
        .d(bubble_cnt + CNT_W'(1)), .q(bubble_cnt)
    );
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed self-checking bench for id_ex_reg against a priority-rule model
module tb_id_ex_reg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int DW    = 4*XLEN + 19;
    logic clk = 1'b0, reset = 1'b1;
    logic hold = 0, bubble = 0, flush = 0, id_valid = 0;
    logic [7:0] id_ctrl = 0;
    logic [XLEN-1:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic [3:0] id_funct = 0;
    logic [7:0] ex_ctrl;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_funct;
    logic ex_valid;
    logic [CNT_W-1:0] bubble_cnt;
    int n_vec = 0, n_bad = 0;
    bit run_cmp = 0;
    logic [7:0] m_ctrl;
    logic m_valid;
    logic [DW-1:0] m_data;
    int m_cnt;

    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    wire [DW-1:0] id_data = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct};
    wire [DW-1:0] ex_data = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct};

    // reference: priority flush > hold > bubble > load, counter saturating at 2^CNT_W-1
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl = 0; m_valid = 0; m_data = 0; m_cnt = 0;
        end else if (flush || !hold) begin
            m_data = id_data;
            if (flush || bubble) begin
                m_ctrl = 0; m_valid = 0;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            end else begin
                m_valid = id_valid;
                m_ctrl  = id_valid ? id_ctrl : 8'h00;
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run_cmp && !reset) begin
        check("cmp_ctrl", 256'(ex_ctrl), 256'(m_ctrl));
        check("cmp_valid", 256'(ex_valid), 256'(m_valid));
        check("cmp_data", 256'(ex_data), 256'(m_data));
        check("cmp_cnt", 256'(bubble_cnt), 256'(m_cnt));
    end

    task automatic drive(input bit h, input bit b, input bit f, input bit v, input logic [7:0] c, input logic [4:0] rd);
        @(negedge clk);
        hold = h; bubble = b; flush = f; id_valid = v; id_ctrl = c; id_rd = rd;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_funct = 4'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("reset_ctrl", 256'(ex_ctrl), 256'h0);
        check("reset_valid", 256'(ex_valid), 256'h0);
        check("reset_data", 256'(ex_data), 256'h0);
        check("reset_cnt", 256'(bubble_cnt), 256'h0);
        @(negedge clk);
        reset = 0;
        run_cmp = 1;
        drive(0, 0, 0, 1, 8'hF0, 5'd5);
        check("lw_ctrl", 256'(ex_ctrl), 256'hF0);
        check("lw_rd", 256'(ex_rd), 256'h5);
        check("lw_valid", 256'(ex_valid), 256'h1);
        check("lw_cnt", 256'(bubble_cnt), 256'h0);
        drive(0, 1, 0, 1, 8'h22, 5'd7);
        check("bub_ctrl", 256'(ex_ctrl), 256'h0);
        check("bub_valid", 256'(ex_valid), 256'h0);
        check("bub_cnt", 256'(bubble_cnt), 256'h1);
        check("bub_rd_loads", 256'(ex_rd), 256'h7);
        drive(0, 0, 0, 1, 8'h22, 5'd7);
        check("after_bub_ctrl", 256'(ex_ctrl), 256'h22);
        drive(0, 0, 0, 1, 8'h88, 5'd9);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 8'h11, 5'd3);
            check("hold_ctrl", 256'(ex_ctrl), 256'h88);
            check("hold_rd", 256'(ex_rd), 256'h9);
            check("hold_cnt", 256'(bubble_cnt), 256'h1);
        end
        drive(1, 0, 1, 1, 8'h05, 5'd4);
        check("flush_ctrl", 256'(ex_ctrl), 256'h0);
        check("flush_valid", 256'(ex_valid), 256'h0);
        check("flush_cnt", 256'(bubble_cnt), 256'h2);
        drive(0, 1, 1, 1, 8'h33, 5'd4);
        check("flush_bub_once", 256'(bubble_cnt), 256'h3);
        drive(0, 0, 0, 0, 8'hFF, 5'd1);
        check("inval_ctrl", 256'(ex_ctrl), 256'h0);
        check("inval_cnt", 256'(bubble_cnt), 256'h3);
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), 5'($urandom));
        drive(0, 0, 0, 1, 8'hA5, 5'd12);
        check("pre_rst_valid", 256'(ex_valid), 256'h1);
        #1 reset = 1;
        #1;
        check("async_rst_ctrl", 256'(ex_ctrl), 256'h0);
        check("async_rst_valid", 256'(ex_valid), 256'h0);
        check("async_rst_data", 256'(ex_data), 256'h0);
        check("async_rst_cnt", 256'(bubble_cnt), 256'h0);
        @(negedge clk);
        reset = 0;
        hold = 0; flush = 0; bubble = 1; id_valid = 1;
        repeat (65534) @(posedge clk);
        #1;
        check("cnt_fffe", 256'(bubble_cnt), 256'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_sat", 256'(bubble_cnt), 256'hFFFF);
        drive(0, 0, 1, 1, 8'h44, 5'd2);
        check("cnt_sat_flush", 256'(bubble_cnt), 256'hFFFF);
        @(negedge clk);
        run_cmp = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-003 SHALL have ports clk input 1 (rising-edge clock) and reset input 1; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports hold input 1 (freeze all contents) and bubble input 1 (insert NOP, load-use hazard).
REQ-005 SHALL have ports flush input 1 (kill ID instruction, taken branch) and id_valid input 1 (ID holds a real instruction).
REQ-006 SHALL have port id_ctrl input 8, ordered {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop[1:0]}.
REQ-007 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm, each input XLEN.
REQ-008 SHALL have ports id_rs1, id_rs2, id_rd, each input 5, and id_funct input 4 ({instr[30],funct3}).
REQ-009 SHALL have ports ex_ctrl output 8, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm output XLEN each, ex_rs1, ex_rs2, ex_rd output 5 each, ex_funct output 4.
REQ-010 SHALL have ports ex_valid output 1 and bubble_cnt output CNT_W (NOPs inserted since reset).

Function
REQ-011 SHALL update only on rising clk; all outputs driven directly from flops, latency exactly 1 cycle ID->EX.
REQ-012 SHALL apply priority per edge: flush > hold > bubble > normal load.
REQ-013 Normal load (no flush/hold/bubble): all ex_* fields take id_* values; ex_valid <= id_valid; ex_ctrl <= id_valid ? id_ctrl : 8'h00.
REQ-014 Flush: ex_ctrl <= 8'h00, ex_valid <= 0; data/index fields load id_* values (don't-care, no gating).
REQ-015 Hold without flush: every register, including bubble_cnt, keeps its value; bubble ignored.
REQ-016 Bubble without hold/flush: ex_ctrl <= 8'h00, ex_valid <= 0; data/index fields load id_* values.
REQ-017 ex_valid=0 SHALL always coincide with ex_ctrl=8'h00 (no side effects from invalid slots).
REQ-018 bubble_cnt SHALL increment by 1 on each edge where flush, or bubble without hold, is applied.
REQ-019 bubble_cnt SHALL saturate at all-ones (no wrap).
REQ-020 bubble_cnt SHALL NOT count slots zeroed only because id_valid=0.
REQ-021 flush and bubble in the same cycle SHALL count once.
REQ-022 Unknown/garbage id_ctrl with id_valid=0 SHALL never reach ex_ctrl.

Reset
REQ-023 Reset asserted SHALL immediately (no clock) force ex_ctrl=8'h00, ex_valid=0, all data/index/funct outputs=0, bubble_cnt=0.
REQ-024 Reset mid-hold or mid-flush SHALL win; first edge after deassertion behaves per REQ-012 on current inputs.

Structure
REQ-025 Shared package SHALL hold the 8-bit control-bundle width and bit positions (ALUSrc=7 ... ALUop=1:0), NOP control constant 8'h00, and register-index width 5.
REQ-026 SHALL use one sub-module pipe_field_reg (parameterised width, async reset, enable, synchronous clear) instantiated for control and data fields.

Verification
REQ-027 Reset then load id_ctrl=8'hF0 (lw), id_valid=1, id_rd=5 -> next edge ex_ctrl=8'hF0, ex_rd=5, ex_valid=1, bubble_cnt=0.
REQ-028 bubble=1 with id_ctrl=8'h22 for one cycle -> ex_ctrl=8'h00, ex_valid=0, bubble_cnt=1; next cycle normal load passes 8'h22.
REQ-029 hold=1 for 3 cycles with ex_ctrl=8'h88 and bubble=1 -> ex_ctrl stays 8'h88, bubble_cnt unchanged.
REQ-030 flush=1 and hold=1 together, id_ctrl=8'h05 -> ex_ctrl=8'h00, ex_valid=0, bubble_cnt +1.
REQ-031 Preload bubble_cnt to 16'hFFFE via bubbles, apply 3 more -> bubble_cnt=16'hFFFF, holds.
REQ-032 Assert reset between edges while ex_valid=1 -> outputs zero before next edge; id_valid=0 with id_ctrl=8'hFF -> ex_ctrl=8'h00, bubble_cnt unchanged.
